// File: rtl/gdsp_pkg.sv
// Shared types and defaults for the TX datapath and its debug capture blocks.
// The capture word keeps the symbol marker alongside the I/Q pair it belongs to.
package gdsp_pkg;

    typedef logic signed [11:0] sample_t;

    typedef enum logic [2:0] {
        CAP_IDLE,
        CAP_PRE,
        CAP_WAIT,
        CAP_POST,
        CAP_DONE
    } cap_state_t;

    typedef struct packed {
        logic    sym;
        sample_t I;
        sample_t Q;
    } cap_word_t;

    localparam int CAP_DEPTH    = 256;
    localparam int CAP_PRE_TRIG = 32;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port RAM (write port A, registered read port B) for snapshot captures.
// The array has no reset so it maps onto block RAM; only the read register clears.
module capture_ram #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 25,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/iq_capture_buffer.sv
// Triggered I/Q snapshot buffer: keeps PRE_TRIG samples ahead of the trigger and
// fills the rest of the DEPTH window after it, then freezes for indexed readout.
module iq_capture_buffer
    import gdsp_pkg::*;
#(
    parameter int DEPTH    = CAP_DEPTH,
    parameter int PRE_TRIG = CAP_PRE_TRIG,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  sample_t       in_I,
    input  sample_t       in_Q,
    input  logic          in_valid,
    input  logic          in_sym_tick,
    input  logic          arm,
    input  logic          force_trig,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_idx,
    output sample_t       rd_I,
    output sample_t       rd_Q,
    output logic          rd_sym,
    output logic          rd_valid,
    output logic          busy,
    output logic          done
);

    localparam int POST_LEN = DEPTH - PRE_TRIG - 1;

    cap_state_t    state, state_next;
    logic [AW-1:0] wr_ptr, wr_ptr_next;
    logic [AW-1:0] pre_cnt, pre_cnt_next;
    logic [AW-1:0] post_cnt, post_cnt_next;
    logic [AW-1:0] trig_addr, trig_addr_next;
    logic [AW-1:0] rd_addr;
    logic          wr_en, trig, rd_fire;
    cap_word_t     wr_word, rd_word;

    assign trig    = in_valid & (in_sym_tick | force_trig);
    assign wr_word = cap_word_t'{sym: in_sym_tick, I: in_I, Q: in_Q};
    assign rd_fire = rd_en & done;
    // Logical index 0 is PRE_TRIG samples before the trigger, wrapping in AW bits.
    assign rd_addr = trig_addr - AW'(PRE_TRIG) + rd_idx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= CAP_IDLE;
            wr_ptr    <= '0;
            pre_cnt   <= '0;
            post_cnt  <= '0;
            trig_addr <= '0;
            rd_valid  <= 1'b0;
        end else begin
            state     <= state_next;
            wr_ptr    <= wr_ptr_next;
            pre_cnt   <= pre_cnt_next;
            post_cnt  <= post_cnt_next;
            trig_addr <= trig_addr_next;
            rd_valid  <= rd_fire;
        end
    end

    always_comb begin
        state_next     = state;
        wr_ptr_next    = wr_ptr;
        pre_cnt_next   = pre_cnt;
        post_cnt_next  = post_cnt;
        trig_addr_next = trig_addr;
        wr_en          = 1'b0;
        busy           = (state == CAP_PRE) || (state == CAP_WAIT) || (state == CAP_POST);
        done           = (state == CAP_DONE);

        if (arm) begin
            // Restart from any state; a sample coincident with arm is dropped.
            state_next   = CAP_PRE;
            wr_ptr_next  = '0;
            pre_cnt_next = '0;
        end else begin
            case (state)
                CAP_PRE: begin
                    if (in_valid) begin
                        wr_en       = 1'b1;
                        wr_ptr_next = wr_ptr + AW'(1);
                        if (pre_cnt == AW'(PRE_TRIG - 1)) begin
                            state_next = CAP_WAIT;
                        end else begin
                            pre_cnt_next = pre_cnt + AW'(1);
                        end
                    end
                end
                CAP_WAIT: begin
                    if (in_valid) begin
                        wr_en       = 1'b1;
                        wr_ptr_next = wr_ptr + AW'(1);
                        if (trig) begin
                            trig_addr_next = wr_ptr;
                            post_cnt_next  = AW'(POST_LEN);
                            state_next     = (POST_LEN == 0) ? CAP_DONE : CAP_POST;
                        end
                    end
                end
                CAP_POST: begin
                    if (in_valid) begin
                        wr_en         = 1'b1;
                        wr_ptr_next   = wr_ptr + AW'(1);
                        post_cnt_next = post_cnt - AW'(1);
                        if (post_cnt == AW'(1)) begin
                            state_next = CAP_DONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    capture_ram #(
        .DEPTH(DEPTH),
        .WIDTH($bits(cap_word_t))
    ) u_ram (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (wr_en),
        .wr_addr(wr_ptr),
        .wr_data(wr_word),
        .rd_en  (rd_fire),
        .rd_addr(rd_addr),
        .rd_data(rd_word)
    );

    assign rd_I   = rd_word.I;
    assign rd_Q   = rd_word.Q;
    assign rd_sym = rd_word.sym;

endmodule

// File: tb/tb_iq_capture_buffer.sv
// Directed bench for iq_capture_buffer with DEPTH=16, PRE_TRIG=4.
// Sample n carries I=n, Q=-n; inputs change and outputs are sampled on negedge.
module tb_iq_capture_buffer;
    import gdsp_pkg::*;

    localparam int DEPTH    = 16;
    localparam int PRE_TRIG = 4;
    localparam int AW       = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    sample_t       in_I, in_Q;
    logic          in_valid, in_sym_tick, arm, force_trig, rd_en;
    logic [AW-1:0] rd_idx;
    sample_t       rd_I, rd_Q;
    logic          rd_sym, rd_valid, busy, done;

    int checks = 0;
    int errors = 0;
    int n      = 0;

    iq_capture_buffer #(.DEPTH(DEPTH), .PRE_TRIG(PRE_TRIG)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_I       (in_I),
        .in_Q       (in_Q),
        .in_valid   (in_valid),
        .in_sym_tick(in_sym_tick),
        .arm        (arm),
        .force_trig (force_trig),
        .rd_en      (rd_en),
        .rd_idx     (rd_idx),
        .rd_I       (rd_I),
        .rd_Q       (rd_Q),
        .rd_sym     (rd_sym),
        .rd_valid   (rd_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic sym, input logic frc);
        in_valid    = 1'b1;
        in_I        = sample_t'(n);
        in_Q        = sample_t'(-n);
        in_sym_tick = sym;
        force_trig  = frc;
        step();
        in_valid    = 1'b0;
        in_sym_tick = 1'b0;
        force_trig  = 1'b0;
        n++;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic rd(input int k);
        rd_idx = AW'(k);
        rd_en  = 1'b1;
        step();
        rd_en  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; arm = 1'b1; in_valid = 1'b0; in_sym_tick = 1'b0;
        force_trig = 1'b0; rd_en = 1'b0; rd_idx = '0; in_I = '0; in_Q = '0;

        // Reset held with arm asserted
        repeat (5) step();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_I", rd_I, 0);
        check("rst_rd_Q", rd_Q, 0);
        rst_n = 1'b1; arm = 1'b0;
        step();
        check("rst_release_busy", busy, 0);

        // Basic capture: trigger at n=4, window = samples 0..15
        n = 0;
        pulse_arm();
        check("basic_busy_after_arm", busy, 1);
        for (int i = 0; i < 16; i++) begin
            send(i % 4 == 0, 1'b0);
            if (i == 14) check("basic_done_before_last", done, 0);
        end
        check("basic_done", done, 1);
        check("basic_busy_end", busy, 0);
        check("basic_rd_valid_idle", rd_valid, 0);
        rd_en = 1'b1;
        for (int k = 0; k < 16; k++) begin
            rd_idx = AW'(k);
            step();
            check($sformatf("basic_valid k=%0d", k), rd_valid, 1);
            check($sformatf("basic_I k=%0d", k), rd_I, k);
            check($sformatf("basic_Q k=%0d", k), rd_Q, -k);
            check($sformatf("basic_sym k=%0d", k), rd_sym, (k % 4 == 0) ? 1 : 0);
        end
        rd_en = 1'b0;
        step();
        check("basic_valid_after_burst", rd_valid, 0);

        // Ring wrap: single tick at n=40
        n = 0;
        pulse_arm();
        for (int i = 0; i < 52; i++) send(i == 40, 1'b0);
        check("wrap_done", done, 1);
        rd(0);  check("wrap_I k=0", rd_I, 36); check("wrap_sym k=0", rd_sym, 0);
        rd(4);  check("wrap_I k=4", rd_I, 40); check("wrap_sym k=4", rd_sym, 1);
        rd(15); check("wrap_I k=15", rd_I, 51); check("wrap_Q k=15", rd_Q, -51);

        // Forced trigger, gappy input; stray forces in PRE and without valid are ignored
        n = 0;
        pulse_arm();
        for (int i = 0; i < 22; i++) begin
            send(1'b0, (i == 1) || (i == 10));
            if (i == 21) begin
                check("force_done", done, 1);
            end else begin
                force_trig = (i == 6);
                step();
                force_trig = 1'b0;
                step();
                if (i == 20) check("force_done_before_last", done, 0);
            end
        end
        rd(0);  check("force_I k=0", rd_I, 6);
        rd(4);  check("force_I k=4", rd_I, 10);
        rd(15); check("force_I k=15", rd_I, 21);

        // Re-arm during POST; the sample alongside arm is dropped
        n = 0;
        pulse_arm();
        for (int i = 0; i < 8; i++) send(i == 4, 1'b0);
        arm = 1'b1;
        send(1'b0, 1'b0);
        arm = 1'b0;
        check("rearm_busy", busy, 1);
        check("rearm_done", done, 0);
        for (int i = 9; i < 25; i++) send(i == 13, 1'b0);
        check("rearm_done_end", done, 1);
        rd(0);  check("rearm_I k=0", rd_I, 9);
        rd(4);  check("rearm_I k=4", rd_I, 13); check("rearm_sym k=4", rd_sym, 1);
        rd(15); check("rearm_I k=15", rd_I, 24);

        // Reset pulse mid-POST
        n = 0;
        pulse_arm();
        for (int i = 0; i < 6; i++) send(i == 4, 1'b0);
        check("midrst_busy_before", busy, 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_rd_I", rd_I, 0);
        for (int i = 0; i < 3; i++) send(1'b1, 1'b0);
        check("midrst_idle_busy", busy, 0);

        // Read gating, then arm together with a read in DONE
        n = 0;
        rd_en = 1'b1; rd_idx = '0;
        pulse_arm();
        for (int i = 0; i < 7; i++) send(i % 4 == 0, 1'b0);
        check("gate_rd_valid", rd_valid, 0);
        check("gate_rd_I_hold", rd_I, 0);
        rd_en = 1'b0;
        for (int i = 7; i < 16; i++) send(i % 4 == 0, 1'b0);
        check("gate_done", done, 1);
        arm = 1'b1; rd_en = 1'b1; rd_idx = AW'(4);
        step();
        arm = 1'b0; rd_en = 1'b0;
        check("armrd_done", done, 0);
        check("armrd_busy", busy, 1);
        check("armrd_valid", rd_valid, 1);
        check("armrd_I", rd_I, 4);
        check("armrd_sym", rd_sym, 1);
        rd(7);
        check("armrd_pre_valid", rd_valid, 0);
        check("armrd_pre_hold", rd_I, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
